rr_vector_arbiter: RTL and testbench
====================================

Name: rr_vector_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the vectorized mux.
- Picks one of NUM_VECTORS valid requesters each cycle and drives the mux select.
- Registers the selected vector into a single-entry valid/ready output stage that feeds issue/dispatch logic.
- Guarantees starvation-free, fair access to a shared downstream datapath slot.

Parameters:
- BIT_WIDTH, 8, bit width of each request vector (power of 2).
- NUM_VECTORS, 4, number of requesters (power of 2, >= 2).
- SEL_W, $clog2(NUM_VECTORS), select/index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_VECTORS  per-requester valid; bit i belongs to requester i.
- req_data  input  NUM_VECTORS*BIT_WIDTH  packed request vectors; requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
- req_ready  output  NUM_VECTORS  one-hot grant; requester i is consumed when req_valid[i] & req_ready[i].
- sel  output  SEL_W  combinational winner index, driving the vectorized mux select.
- out_valid  output  1  output register holds a valid vector.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  BIT_WIDTH  registered selected vector.
- out_src  output  SEL_W  registered index of the requester that produced out_data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_src=0, pointer ptr=0.
  - Reset overrides everything, including an in-flight transfer; the held entry is dropped.
- Pointer: ptr is the highest-priority index. Priority order is ptr, ptr+1, ..., ptr-1 (mod NUM_VECTORS).
- Winner: the first index in priority order with req_valid set. sel=winner when any req_valid is set, else sel=ptr.
- load = (~out_valid | out_ready) & |req_valid.
- req_ready = onehot(winner) when load, else all zeros. Purely combinational; depends on out_ready in the same cycle.
- On a load edge:
  - out_data <= req_data slice [winner]; out_src <= winner; out_valid <= 1.
  - ptr <= winner+1 (mod NUM_VECTORS; wraps N-1 -> 0).
- Latency: one cycle from request acceptance to out_valid.
- Throughput: one vector per cycle when out_ready is held high.
- Drain: out_valid & out_ready & ~|req_valid -> out_valid <= 0. out_data and out_src keep their last value.
- Backpressure: out_valid & ~out_ready -> out_data, out_src, out_valid and ptr all hold; req_ready=0.
- Simultaneous drain and load in the same cycle: the output register is replaced, with no bubble.
- ptr advances only on a grant. Idle cycles and stalled cycles never move it.
- Requesters must hold req_data stable while req_valid is high and not yet granted. The arbiter never reorders within one requester.
- All arithmetic is unsigned modulo NUM_VECTORS; index math uses SEL_W bits only.
- No X propagation: sel is defined every cycle, including when no request is present.

Decomposition:
- Shared package arb_pkg:
  - localparam/function for SEL_W from NUM_VECTORS.
  - function rr_next(ptr) giving wrap-increment.
  - function onehot(idx, N).
- Sub-module rr_pick (combinational):
  - inputs req_valid and ptr.
  - outputs winner index and any_valid.
  - implemented as a rotate, priority-encode, un-rotate sequence.
- Data selection uses the team's existing vectorized mux, instanced with sel=winner. rr_vector_arbiter adds the pointer, the handshake and the output register.

Test Plan:
- Reset mid-stream: out_valid=1 with out_data=8'd20, assert rst for one cycle -> next cycle out_valid=0, out_data=0, out_src=0, ptr=0; with req_valid=4'b1111 the first grant afterwards is to index 0.
- Fairness with all requesters active: req_valid=4'b1111, data {30,20,10,1} (index 3..0), out_ready=1 -> out_data sequence 1,10,20,30,1 on consecutive cycles; out_src 0,1,2,3,0; ptr wraps from 3 to 0.
- Sparse requests: req_valid=4'b1010, ptr=0 -> grant index 1 (out_data=10); next cycle grant index 3 (out_data=30); then back to index 1; indices 0 and 2 are never granted.
- Backpressure: out_valid=1, out_data=10, out_ready=0 for 3 cycles with req_valid=4'b1111 -> req_ready=0, out_data stays 10, ptr stays 2; when out_ready=1, the same cycle grants index 2 and out_data=20 on the next edge.
- Drain then idle: single request req_valid=4'b0100, out_ready=1 -> out_valid=1 for one cycle with out_data=20; then req_valid=0 -> out_valid=0, and sel=ptr=3 while idle.
- Late request during a stall: out_ready=0, requester 0 raises at ptr=1 while requester 2 is valid -> on release, index 2 wins first (priority order), and index 0 is granted on the following cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin vector arbiter slice.
//   sel_width : index width for a given requester count
//   rr_next   : wrap-increment of a round-robin pointer
//   onehot    : one-hot decode of an index, LSB-aligned in MAX_VECTORS bits
package arb_pkg;

    // Upper bound on requester count supported by the one-hot helper.
    localparam int unsigned MAX_VECTORS = 64;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned n);
        return (ptr + 1) % n;
    endfunction

    function automatic logic [MAX_VECTORS-1:0] onehot(input int unsigned idx,
                                                      input int unsigned n);
        logic [MAX_VECTORS-1:0] result;
        result = '0;
        if (idx < n && idx < MAX_VECTORS) begin
            result[idx] = 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr.
//   req_valid : per-requester valid bits
//   ptr       : highest-priority index
//   winner    : chosen index (equals ptr when nothing is valid)
//   any_valid : at least one requester is valid
module rr_pick #(
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned SEL_W       = 2
) (
    input  logic [NUM_VECTORS-1:0] req_valid,
    input  logic [SEL_W-1:0]       ptr,
    output logic [SEL_W-1:0]       winner,
    output logic                   any_valid
);

    logic [NUM_VECTORS-1:0] rotated;
    logic [SEL_W-1:0]       offset;
    logic                   found;

    always_comb begin
        // Rotate so that ptr lands at bit 0; bit k then means index ptr+k.
        rotated = NUM_VECTORS'({req_valid, req_valid} >> ptr);

        offset = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_VECTORS; i++) begin
            if (rotated[i] && !found) begin
                offset = SEL_W'(i);
                found  = 1'b1;
            end
        end

        // Un-rotate; NUM_VECTORS is a power of two so the SEL_W-bit add wraps mod N.
        winner    = ptr + offset;
        any_valid = |req_valid;
    end

endmodule

// File: rtl/vector_mux.sv
// Vectorized mux: selects one BIT_WIDTH slice out of NUM_VECTORS packed vectors.
//   data_in  : packed vectors, vector i at [i*BIT_WIDTH +: BIT_WIDTH]
//   sel      : index of the vector to forward
//   data_out : selected vector
module vector_mux #(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned SEL_W       = 2
) (
    input  logic [NUM_VECTORS*BIT_WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]                 sel,
    output logic [BIT_WIDTH-1:0]             data_out
);

    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < NUM_VECTORS; i++) begin
            if (sel == SEL_W'(i)) begin
                data_out = data_in[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rr_vector_arbiter.sv
// Round-robin arbiter feeding a single-entry valid/ready output register.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   req_valid : per-requester valid
//   req_data  : packed request vectors, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//   req_ready : one-hot grant, combinational (depends on out_ready this cycle)
//   sel       : combinational winner index driving the vector mux
//   out_valid : output register holds a vector
//   out_ready : downstream accepts out_data this cycle
//   out_data  : registered selected vector
//   out_src   : registered index of the requester that produced out_data
module rr_vector_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 8,
    parameter int unsigned NUM_VECTORS = 4,
    localparam int unsigned SEL_W      = sel_width(NUM_VECTORS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_VECTORS-1:0]           req_valid,
    input  logic [NUM_VECTORS*BIT_WIDTH-1:0] req_data,
    output logic [NUM_VECTORS-1:0]           req_ready,
    output logic [SEL_W-1:0]                 sel,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [BIT_WIDTH-1:0]             out_data,
    output logic [SEL_W-1:0]                 out_src
);

    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     winner;
    logic                 any_valid;
    logic                 load;
    logic [BIT_WIDTH-1:0] mux_out;
    int unsigned          winner_idx;

    rr_pick #(
        .NUM_VECTORS (NUM_VECTORS),
        .SEL_W       (SEL_W)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    vector_mux #(
        .BIT_WIDTH   (BIT_WIDTH),
        .NUM_VECTORS (NUM_VECTORS),
        .SEL_W       (SEL_W)
    ) u_mux (
        .data_in  (req_data),
        .sel      (winner),
        .data_out (mux_out)
    );

    // Output slot is free when empty or being drained this same cycle.
    assign load       = (~out_valid | out_ready) & any_valid;
    assign winner_idx = 32'(winner);
    assign sel        = winner;
    assign req_ready  = load ? NUM_VECTORS'(onehot(winner_idx, NUM_VECTORS)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mux_out;
            out_src   <= winner;
            ptr       <= SEL_W'(rr_next(winner_idx, NUM_VECTORS));
        end else if (out_ready) begin
            // Drain with nothing to refill; data/src keep their last value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_vector_arbiter.sv
module tb_rr_vector_arbiter;

    localparam int unsigned BW = 8;
    localparam int unsigned N  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*BW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [1:0]    sel;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [1:0]    out_src;

    int vectors     = 0;
    int miscompares = 0;

    rr_vector_arbiter #(
        .BIT_WIDTH   (BW),
        .NUM_VECTORS (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       ready;
        logic [3:0] rdy;
        logic [1:0] sel;
        logic       ov;
        logic [7:0] od;
        logic [1:0] os;
    } vec_t;

    vec_t tbl[25];

    // Reference model state
    int         m_ptr;
    bit         m_ov;
    int         m_od;
    int         m_os;
    bit         pend[N];
    logic [7:0] pdata[N];

    function automatic int model_winner();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    initial begin
        // fixed data: index 3..0 = 30,20,10,1
        tbl[0]  = '{0, 4'hF, 1, 4'b0001, 2'd0, 1, 8'd1,  2'd0};
        tbl[1]  = '{0, 4'hF, 1, 4'b0010, 2'd1, 1, 8'd10, 2'd1};
        tbl[2]  = '{0, 4'hF, 1, 4'b0100, 2'd2, 1, 8'd20, 2'd2};
        tbl[3]  = '{0, 4'hF, 1, 4'b1000, 2'd3, 1, 8'd30, 2'd3};
        tbl[4]  = '{0, 4'hF, 1, 4'b0001, 2'd0, 1, 8'd1,  2'd0};
        tbl[5]  = '{0, 4'hA, 1, 4'b0010, 2'd1, 1, 8'd10, 2'd1};
        tbl[6]  = '{0, 4'hA, 1, 4'b1000, 2'd3, 1, 8'd30, 2'd3};
        tbl[7]  = '{0, 4'hA, 1, 4'b0010, 2'd1, 1, 8'd10, 2'd1};
        tbl[8]  = '{0, 4'hF, 0, 4'b0000, 2'd2, 1, 8'd10, 2'd1};
        tbl[9]  = '{0, 4'hF, 0, 4'b0000, 2'd2, 1, 8'd10, 2'd1};
        tbl[10] = '{0, 4'hF, 0, 4'b0000, 2'd2, 1, 8'd10, 2'd1};
        tbl[11] = '{0, 4'hF, 1, 4'b0100, 2'd2, 1, 8'd20, 2'd2};
        tbl[12] = '{0, 4'h4, 1, 4'b0100, 2'd2, 1, 8'd20, 2'd2};
        tbl[13] = '{0, 4'h0, 1, 4'b0000, 2'd3, 0, 8'd20, 2'd2};
        tbl[14] = '{0, 4'h0, 1, 4'b0000, 2'd3, 0, 8'd20, 2'd2};
        tbl[15] = '{0, 4'h1, 0, 4'b0001, 2'd0, 1, 8'd1,  2'd0};
        tbl[16] = '{0, 4'h4, 0, 4'b0000, 2'd2, 1, 8'd1,  2'd0};
        tbl[17] = '{0, 4'h5, 0, 4'b0000, 2'd2, 1, 8'd1,  2'd0};
        tbl[18] = '{0, 4'h5, 1, 4'b0100, 2'd2, 1, 8'd20, 2'd2};
        tbl[19] = '{0, 4'h1, 1, 4'b0001, 2'd0, 1, 8'd1,  2'd0};
        tbl[20] = '{0, 4'h4, 1, 4'b0100, 2'd2, 1, 8'd20, 2'd2};
        tbl[21] = '{1, 4'hF, 1, 4'b1000, 2'd3, 0, 8'd0,  2'd0};
        tbl[22] = '{0, 4'hF, 1, 4'b0001, 2'd0, 1, 8'd1,  2'd0};
        tbl[23] = '{0, 4'h0, 0, 4'b0000, 2'd1, 1, 8'd1,  2'd0};
        tbl[24] = '{0, 4'h0, 1, 4'b0000, 2'd1, 0, 8'd1,  2'd0};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data",  int'(out_data),  0);
        chk("reset_out_src",   int'(out_src),   0);
        #1;
        chk("reset_idle_sel",  int'(sel),       0);

        // Directed table
        req_data = {8'd30, 8'd20, 8'd10, 8'd1};
        for (int i = 0; i < 25; i++) begin
            rst       = tbl[i].rst;
            req_valid = tbl[i].valid;
            out_ready = tbl[i].ready;
            #1;
            chk($sformatf("tbl%0d_req_ready", i), int'(req_ready), int'(tbl[i].rdy));
            chk($sformatf("tbl%0d_sel", i),       int'(sel),       int'(tbl[i].sel));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
            chk($sformatf("tbl%0d_out_data", i),  int'(out_data),  int'(tbl[i].od));
            chk($sformatf("tbl%0d_out_src", i),   int'(out_src),   int'(tbl[i].os));
        end

        // Randomized run against the reference model
        rst = 1'b1; req_valid = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0; m_ov = 0; m_od = 0; m_os = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            int  w;
            bit  ld;
            bit  do_rst;
            logic [N-1:0] exp_rdy;
            int  exp_sel;

            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 40)) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 8'($urandom);
                end
                req_valid[i] = pend[i];
                req_data[i*BW +: BW] = pend[i] ? pdata[i] : 8'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < 70);
            do_rst    = ($urandom_range(0, 63) == 0);
            rst       = do_rst;

            w  = model_winner();
            ld = (!m_ov || out_ready) && (w >= 0);
            exp_rdy = '0;
            if (ld) exp_rdy[w] = 1'b1;
            exp_sel = (w >= 0) ? w : m_ptr;

            #1;
            chk("rand_req_ready", int'(req_ready), int'(exp_rdy));
            chk("rand_sel",       int'(sel),       exp_sel);
            @(posedge clk);

            // A granted requester is consumed even if reset drops the entry.
            if (ld) pend[w] = 1'b0;
            if (do_rst) begin
                m_ptr = 0; m_ov = 0; m_od = 0; m_os = 0;
            end else if (ld) begin
                m_ov  = 1;
                m_od  = int'(pdata[w]);
                m_os  = w;
                m_ptr = (w + 1) % N;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end

            #1;
            chk("rand_out_valid", int'(out_valid), int'(m_ov));
            chk("rand_out_data",  int'(out_data),  m_od);
            chk("rand_out_src",   int'(out_src),   m_os);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
